// File: rtl/bit_deserializer.sv
// Bit-serial to parallel deserializer, MSB first.
// val/rdy on both sides; words stream back-to-back with no bubble.
module bit_deserializer #(
    parameter int unsigned nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic             in_,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out
);

    localparam int unsigned CW = $clog2(nbits + 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e           state_q;
    logic [nbits-1:0] sreg_q;
    logic [CW-1:0]    cnt_q;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(nbits - 1));

    // Only FULL lets backpressure reach the serial side.
    assign in_rdy  = (state_q == FILL) | out_rdy;
    assign out_val = (state_q == FULL);
    assign out     = (state_q == FULL) ? sreg_q : '0;

    // Shift in bits while filling; release the word and restart when full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (in_val) begin
                        sreg_q <= {sreg_q[nbits-2:0], in_};
                        if (last_bit) begin
                            cnt_q   <= '0;
                            state_q <= FULL;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (out_rdy) begin
                        state_q <= FILL;
                        if (in_val) begin
                            sreg_q <= {{(nbits-1){1'b0}}, in_};
                            cnt_q  <= CW'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

endmodule
